fft_cfg_sink: RTL and testbench
===============================

// Module: fft_cfg_sink
// PURPOSE
//  Receiving end of the FFT configuration channel (valid/ready, one beat per config word).
//  Accepts a config word, holds it pending while an FFT frame is in progress, and commits it at the
//  frame boundary so every frame runs with one consistent config.
//  Also counts accepted data beats per frame and flags tlast framing errors.
//  Sits between config producers (e.g. the power-up config pulse) and the FFT datapath control.
// PARAMETERS
//  CFG_W      16       config word width; bit FWD_BIT is forward(1)/inverse(0), other bits opaque
//  FWD_BIT    0        index of the forward/inverse bit within the config word
//  NFFT_LOG2  10       log2 of transform length; frame = 2**NFFT_LOG2 accepted data beats
//  RESET_CFG  16'h0001 config in force out of reset (forward transform)
// PORTS
//  i_clk            in   1          clock
//  i_rstn           in   1          async active-low reset
//  i_cfg_valid      in   1          config beat offered
//  i_cfg_data       in   CFG_W      config word
//  o_cfg_ready      out  1          sink can take a config beat
//  i_dat_valid      in   1          data-channel valid (monitored only)
//  i_dat_ready      in   1          data-channel ready (monitored only); beat = valid & ready
//  i_dat_last       in   1          data-channel last (monitored only)
//  o_cfg_word       out  CFG_W      committed config in force
//  o_fwd_inv        out  1          o_cfg_word[FWD_BIT]
//  o_cfg_pending    out  1          accepted config waiting for frame boundary
//  o_cfg_applied    out  1          1-cycle pulse: o_cfg_word just updated
//  o_sample_idx     out  NFFT_LOG2  index of next expected data beat in frame
//  o_evt_tlast_missing    out 1     1-cycle pulse: final beat arrived without last
//  o_evt_tlast_unexpected out 1     1-cycle pulse: last asserted on non-final beat
// BEHAVIOUR
//  Reset (async, i_rstn low): o_cfg_word=RESET_CFG, o_fwd_inv=RESET_CFG[FWD_BIT], o_cfg_ready=1,
//   o_cfg_pending=0, o_cfg_applied=0, o_sample_idx=0, both evt=0; pending word discarded.
//  cfg handshake = i_cfg_valid & o_cfg_ready on a rising edge. o_cfg_ready = !o_cfg_pending (registered).
//  Data beat = i_dat_valid & i_dat_ready. o_sample_idx increments per beat, wraps NFFT-1 -> 0 (mod 2**NFFT_LOG2).
//  Frame in progress <=> o_sample_idx != 0.
//  States: IDLE (no pending), PEND (pending word held, ready=0).
//   IDLE, handshake, idx==0 and no beat this edge -> commit immediately: o_cfg_word updated at that
//     edge, o_cfg_applied=1 next cycle; stay IDLE.
//   IDLE, handshake, idx==NFFT-1 and beat this edge (boundary edge) -> commit immediately as above.
//   IDLE, handshake, otherwise (incl. idx==0 with beat = first beat of frame) -> store word, go PEND;
//     the just-started frame keeps the old config.
//   PEND, beat with idx==NFFT-1 -> commit stored word at that edge, o_cfg_applied next cycle, -> IDLE.
//   PEND, no boundary -> hold; i_cfg_valid ignored (ready=0, producer must hold valid & data stable).
//  Commit latency: 1 edge; o_cfg_word changes on the committing edge, o_cfg_applied high the cycle after.
//  tlast checks (evaluated on each beat, pulses registered, 1 cycle after the beat):
//   idx==NFFT-1 & !last -> o_evt_tlast_missing; idx!=NFFT-1 & last -> o_evt_tlast_unexpected.
//   Framing follows the counter only; last never resynchronises o_sample_idx.
//  No-beat cycles never change idx. Back-to-back commits allowed (one per frame boundary max via PEND).
//  i_cfg_valid with X data is never sampled unless ready=1.
// STRUCTURE
//  fft_pkg: CFG_W, FWD_BIT, NFFT_LOG2 defaults, RESET_CFG, cfg-sink state enum {IDLE, PEND}.
//  Sub-module fft_frame_counter: beat in, last in -> idx, o_boundary (beat & idx==NFFT-1),
//   tlast error pulses; reused by the data-path monitors.
//  Top: 2-state FSM, pending register, committed register, applied pulse.
// TESTING
//  T1 reset: drive i_rstn low mid-frame with PEND -> all outputs at reset values, pending lost, idx=0.
//  T2 idle commit: idx=0, offer cfg 16'h0000, no beats -> handshake in 1 cycle, o_fwd_inv=0 next edge,
//     o_cfg_applied pulse 1 cycle, o_cfg_pending stays 0.
//  T3 mid-frame: NFFT_LOG2=3, send 3 beats, offer 16'h0000 -> pending=1, ready=0, fwd_inv stays 1
//     until 8th beat edge; then fwd_inv=0, applied pulse, ready=1.
//  T4 simultaneity: cfg handshake on same edge as beat idx=0 -> pending, commit at idx=7 beat;
//     handshake on same edge as beat idx=7 -> immediate commit, pending never set.
//  T5 tlast: NFFT=8, last on beat 5 -> unexpected pulse; no last on beat 7 -> missing pulse;
//     idx wraps to 0 regardless.
//  T6 backpressure: hold i_cfg_valid with word A through PEND, change nothing -> exactly one commit of A,
//     then second word B accepted after boundary and committed at next boundary.

Source files
------------

// File: rtl/fft_cfg_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_cfg_sink_pkg
//  Description : Shared defaults and state encoding for the FFT config sink
//                and its frame counter.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_cfg_sink_pkg;

    localparam int          CFG_W_DEF     = 16;
    localparam int          FWD_BIT_DEF   = 0;
    localparam int          NFFT_LOG2_DEF = 10;
    localparam logic [15:0] RESET_CFG_DEF = 16'h0001;

    // IDLE: nothing held, channel open. PEND: a word waits for the frame end.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } sink_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_cfg_sink_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_cfg_if
//  Description : Valid/ready config channel, one config word per beat.
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_cfg_if #(
    parameter int CFG_W = 16
) ();
    logic             valid;
    logic             ready;
    logic [CFG_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/fft_cfg_sink_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_counter
//  Description : Counts accepted data beats within a 2**NFFT_LOG2 frame,
//                flags the frame-final beat and reports tlast framing errors.
//                The counter alone defines framing; last never resyncs it.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_frame_counter #(
    parameter int NFFT_LOG2 = 10
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rstn,
    input  wire logic                 i_beat,
    input  wire logic                 i_last,
    output logic     [NFFT_LOG2-1:0]  o_idx,
    output logic                      o_boundary,
    output logic                      o_evt_tlast_missing,
    output logic                      o_evt_tlast_unexpected
);

    localparam logic [NFFT_LOG2-1:0] LAST_IDX = {NFFT_LOG2{1'b1}};

    logic at_final;

    assign at_final   = (o_idx == LAST_IDX);
    assign o_boundary = i_beat & at_final;

    // Advance the index per beat (natural wrap) and register tlast checks.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_idx                  <= '0;
            o_evt_tlast_missing    <= 1'b0;
            o_evt_tlast_unexpected <= 1'b0;
        end else begin
            if (i_beat) begin
                o_idx <= o_idx + NFFT_LOG2'(1);
            end
            o_evt_tlast_missing    <= i_beat &  at_final & ~i_last;
            o_evt_tlast_unexpected <= i_beat & ~at_final &  i_last;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_cfg_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fft_cfg_sink
//  Description : Accepts FFT config words and commits them only at frame
//                boundaries so each frame runs with one consistent config.
//                Also tracks the data frame position and tlast errors.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_cfg_sink
    import fft_cfg_sink_pkg::*;
#(
    parameter int               CFG_W     = CFG_W_DEF,
    parameter int               FWD_BIT   = FWD_BIT_DEF,
    parameter int               NFFT_LOG2 = NFFT_LOG2_DEF,
    parameter logic [CFG_W-1:0] RESET_CFG = CFG_W'(RESET_CFG_DEF)
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rstn,
    fft_cfg_if.slave                  cfg,
    input  wire logic                 i_dat_valid,
    input  wire logic                 i_dat_ready,
    input  wire logic                 i_dat_last,
    output logic     [CFG_W-1:0]      o_cfg_word,
    output logic                      o_fwd_inv,
    output logic                      o_cfg_pending,
    output logic                      o_cfg_applied,
    output logic     [NFFT_LOG2-1:0]  o_sample_idx,
    output logic                      o_evt_tlast_missing,
    output logic                      o_evt_tlast_unexpected
);

    sink_state_t      state;
    sink_state_t      state_nxt;
    logic [CFG_W-1:0] pend_word;
    logic [CFG_W-1:0] commit_word;
    logic             commit;
    logic             store;
    logic             beat;
    logic             boundary;

    assign beat = i_dat_valid & i_dat_ready;

    fft_frame_counter #(
        .NFFT_LOG2 (NFFT_LOG2)
    ) u_frame_counter (
        .i_clk                  (i_clk),
        .i_rstn                 (i_rstn),
        .i_beat                 (beat),
        .i_last                 (i_dat_last),
        .o_idx                  (o_sample_idx),
        .o_boundary             (boundary),
        .o_evt_tlast_missing    (o_evt_tlast_missing),
        .o_evt_tlast_unexpected (o_evt_tlast_unexpected)
    );

    // Ready comes straight from the state flop, so it is registered.
    assign cfg.ready     = (state == ST_IDLE);
    assign o_cfg_pending = (state == ST_PEND);
    assign o_fwd_inv     = o_cfg_word[FWD_BIT];

    // Decide whether an offered word commits now or waits for the frame end.
    always_comb begin
        state_nxt   = state;
        commit      = 1'b0;
        store       = 1'b0;
        commit_word = pend_word;
        case (state)
            ST_IDLE: begin
                if (cfg.valid) begin
                    commit_word = cfg.data;
                    // Between frames, or on the edge that closes one: safe now.
                    if (((o_sample_idx == '0) && !beat) || boundary) begin
                        commit = 1'b1;
                    end else begin
                        store     = 1'b1;
                        state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (boundary) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, held word, committed word and the one-cycle applied pulse.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= ST_IDLE;
            pend_word     <= '0;
            o_cfg_word    <= RESET_CFG;
            o_cfg_applied <= 1'b0;
        end else begin
            state         <= state_nxt;
            o_cfg_applied <= commit;
            if (store) begin
                pend_word <= cfg.data;
            end
            if (commit) begin
                o_cfg_word <= commit_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_cfg_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_cfg_sink
//  Description : Self-checking bench for fft_cfg_sink (8-beat frames).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_cfg_sink;

    localparam int          CFG_W   = 16;
    localparam int          FWD_BIT = 0;
    localparam int          NL      = 3;
    localparam int          N       = 8;
    localparam logic [15:0] RST_CFG = 16'h0001;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic            dat_valid, dat_ready, dat_last;
    logic [CFG_W-1:0] cfg_word;
    logic            fwd_inv, cfg_pending, cfg_applied;
    logic [NL-1:0]   sample_idx;
    logic            evt_missing, evt_unexpected;

    fft_cfg_if #(.CFG_W(CFG_W)) cfg_bus ();

    fft_cfg_sink #(
        .CFG_W     (CFG_W),
        .FWD_BIT   (FWD_BIT),
        .NFFT_LOG2 (NL),
        .RESET_CFG (RST_CFG)
    ) dut (
        .i_clk                  (clk),
        .i_rstn                 (rstn),
        .cfg                    (cfg_bus.slave),
        .i_dat_valid            (dat_valid),
        .i_dat_ready            (dat_ready),
        .i_dat_last             (dat_last),
        .o_cfg_word             (cfg_word),
        .o_fwd_inv              (fwd_inv),
        .o_cfg_pending          (cfg_pending),
        .o_cfg_applied          (cfg_applied),
        .o_sample_idx           (sample_idx),
        .o_evt_tlast_missing    (evt_missing),
        .o_evt_tlast_unexpected (evt_unexpected)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: committed word, optional held word, frame position.
    logic [15:0] m_word, m_pword;
    bit          m_pend, m_applied, m_miss, m_unexp;
    int          m_idx;

    typedef struct {
        bit          cv;
        logic [15:0] cd;
        bit          dv, dr, last;
        logic [15:0] e_word;
        bit          e_pend, e_app;
        int          e_idx;
        bit          e_miss, e_unexp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_word = RST_CFG; m_pword = '0; m_pend = 0;
        m_applied = 0; m_miss = 0; m_unexp = 0; m_idx = 0;
    endtask

    // One rising edge: the rules written directly from the channel behaviour.
    task automatic model_edge(input bit cv, input logic [15:0] cd,
                              input bit dv, input bit dr, input bit last);
        bit beat, frame_end;
        beat      = dv && dr;
        frame_end = beat && (m_idx == N - 1);
        m_applied = 0;
        if (m_pend) begin
            if (frame_end) begin
                m_word = m_pword; m_pend = 0; m_applied = 1;
            end
        end else if (cv) begin
            if ((m_idx == 0 && !beat) || frame_end) begin
                m_word = cd; m_applied = 1;
            end else begin
                m_pword = cd; m_pend = 1;
            end
        end
        m_miss  = frame_end && !last;
        m_unexp = beat && (m_idx != N - 1) && last;
        if (beat) m_idx = (m_idx + 1) % N;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_word"},    32'(cfg_word),       32'(m_word));
        chk({tag, "_fwd"},     32'(fwd_inv),        32'(m_word[FWD_BIT]));
        chk({tag, "_pending"}, 32'(cfg_pending),    32'(m_pend));
        chk({tag, "_ready"},   32'(cfg_bus.ready),  32'(!m_pend));
        chk({tag, "_applied"}, 32'(cfg_applied),    32'(m_applied));
        chk({tag, "_idx"},     32'(sample_idx),     32'(m_idx));
        chk({tag, "_missing"}, 32'(evt_missing),    32'(m_miss));
        chk({tag, "_unexp"},   32'(evt_unexpected), 32'(m_unexp));
    endtask

    task automatic drive(input bit cv, input logic [15:0] cd,
                         input bit dv, input bit dr, input bit last);
        cfg_bus.valid = cv; cfg_bus.data = cd;
        dat_valid = dv; dat_ready = dr; dat_last = last;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge(cfg_bus.valid, cfg_bus.data, dat_valid, dat_ready, dat_last);
        @(negedge clk);
        check_model(tag);
    endtask

    function automatic void add(input bit cv, input logic [15:0] cd, input bit dv,
                                input bit dr, input bit last, input logic [15:0] ew,
                                input bit ep, input bit ea, input int ei,
                                input bit em, input bit eu);
        vec_t v;
        v.cv = cv; v.cd = cd; v.dv = dv; v.dr = dr; v.last = last;
        v.e_word = ew; v.e_pend = ep; v.e_app = ea; v.e_idx = ei;
        v.e_miss = em; v.e_unexp = eu;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [15:0] words[2];
        logic [15:0] commits[$];
        int          wi;
        bit          hs_now;

        // Directed table; expectations are the outputs after each edge.
        add(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0); // idle commit
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add(1, 16'h0001, 1, 1, 0, 16'h0000, 1, 0, 1, 0, 0); // cfg with first beat
        add(1, 16'hFFFF, 1, 1, 0, 16'h0000, 1, 0, 2, 0, 0); // ignored while pending
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 2, 0, 0); // no beat
        add(0, 16'h0000, 1, 1, 1, 16'h0000, 1, 0, 3, 0, 1); // early last
        for (int i = 4; i <= 7; i++) add(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, i, 0, 0);
        add(0, 16'h0000, 1, 1, 1, 16'h0001, 0, 1, 0, 0, 0); // boundary commit
        add(1, 16'h0000, 1, 1, 0, 16'h0001, 1, 0, 1, 0, 0);
        for (int i = 2; i <= 7; i++) add(0, 16'h0000, 1, 1, 0, 16'h0001, 1, 0, i, 0, 0);
        add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 1, 0, 1, 0); // commit + missing last
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, i, 0, 0);
        add(1, 16'h0001, 1, 1, 1, 16'h0001, 0, 1, 0, 0, 0); // cfg on boundary edge
        add(0, 16'h0000, 0, 0, 0, 16'h0001, 0, 0, 0, 0, 0);

        // Reset values
        model_reset();
        drive(0, '0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_word", 32'(cfg_word), 32'(RST_CFG));
        chk("rst_ready", 32'(cfg_bus.ready), 32'd1);
        check_model("rst");
        rstn = 1'b1;

        // Table
        foreach (vecs[k]) begin
            drive(vecs[k].cv, vecs[k].cd, vecs[k].dv, vecs[k].dr, vecs[k].last);
            step("tbl_model");
            chk($sformatf("tbl%0d_word", k),    32'(cfg_word),       32'(vecs[k].e_word));
            chk($sformatf("tbl%0d_fwd", k),     32'(fwd_inv),        32'(vecs[k].e_word[0]));
            chk($sformatf("tbl%0d_pending", k), 32'(cfg_pending),    32'(vecs[k].e_pend));
            chk($sformatf("tbl%0d_ready", k),   32'(cfg_bus.ready),  32'(!vecs[k].e_pend));
            chk($sformatf("tbl%0d_applied", k), 32'(cfg_applied),    32'(vecs[k].e_app));
            chk($sformatf("tbl%0d_idx", k),     32'(sample_idx),     32'(vecs[k].e_idx));
            chk($sformatf("tbl%0d_missing", k), 32'(evt_missing),    32'(vecs[k].e_miss));
            chk($sformatf("tbl%0d_unexp", k),   32'(evt_unexpected), 32'(vecs[k].e_unexp));
        end

        // Async reset mid-frame while a word is pending
        for (int i = 0; i < 3; i++) begin drive(0, '0, 1, 1, 0); step("t1_pre"); end
        drive(1, 16'h0000, 1, 1, 0); step("t1_offer");
        drive(0, '0, 1, 1, 0); step("t1_hold");
        chk("t1_pend_before", 32'(cfg_pending), 32'd1);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("t1_word",    32'(cfg_word),    32'(RST_CFG));
        chk("t1_fwd",     32'(fwd_inv),     32'd1);
        chk("t1_pending", 32'(cfg_pending), 32'd0);
        chk("t1_ready",   32'(cfg_bus.ready), 32'd1);
        chk("t1_applied", 32'(cfg_applied), 32'd0);
        chk("t1_idx",     32'(sample_idx),  32'd0);
        drive(0, '0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        // The discarded word must never appear at a later frame end.
        for (int i = 0; i < 10; i++) begin drive(0, '0, 1, 1, (i % N) == N - 1); step("t1_post"); end

        // Backpressure: A offered mid-frame, B held behind it with valid high
        while (m_idx != 3) begin drive(0, '0, 1, 1, m_idx == N - 1); step("t6_align"); end
        words[0] = 16'h00A0; words[1] = 16'h0B01; wi = 0;
        for (int i = 0; i < 24; i++) begin
            drive(wi < 2, (wi < 2) ? words[wi] : 16'h0000, 1, 1, m_idx == N - 1);
            hs_now = cfg_bus.valid && cfg_bus.ready;
            step("t6");
            if (cfg_applied) commits.push_back(cfg_word);
            if (hs_now) wi++;
        end
        chk("t6_commit_count", 32'(commits.size()), 32'd2);
        if (commits.size() == 2) begin
            chk("t6_first",  32'(commits[0]), 32'(words[0]));
            chk("t6_second", 32'(commits[1]), 32'(words[1]));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit lst;
            lst = (m_idx == N - 1);
            if ($urandom_range(0, 9) == 0) lst = !lst;
            drive($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, lst);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
